pll_reconfig_ctrl: RTL and testbench

// - DRP sequencer upstream of the Amiga clock PLL. It reprograms the PLL between PAL and NTSC clock sets.
//   - PAL: 113.46/28.37 MHz (M59 D2 O0=13 O1=52).
//   - NTSC: 114.58/28.65 MHz (M55 D2 O0=12 O1=48).
// - Holds the PLL in reset and writes 12 DRP registers from an internal table.
// - Releases reset, then waits for lock. The PLL exposes no DRP read data, so writes are full-word (no read-modify-write).

---
 rtl/pll_reconfig_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl
//   DRP sequencer for the Amiga clock PLL. It switches the PLL between the PAL clock set
//   (113.46/28.37 MHz) and the NTSC clock set (114.58/28.65 MHz). While the PLL is held in reset,
//   it writes 12 full-word DRP registers from an internal table, then releases reset and waits
//   for lock. The PLL gives no DRP read data, so no read-modify-write is done.
//
// Parameters
//   RST_SETTLE    cycles pll_rst is held before the first write (>= 3 so the lock sync flushes)
//   RDY_TIMEOUT   max cycles from a write strobe to drp_ready before error
//   LOCK_TIMEOUT  max cycles from pll_rst release to synchronised lock before error
//
// Ports
//   i_drp_clk     sole clock (also the PLL DRP clock)
//   i_rst         synchronous active-high reset
//   i_ntsc_sel    requested mode, 1 = NTSC, 0 = PAL
//   i_pll_locked  PLL lock, asynchronous (2-flop synchronised here)
//   o_pll_rst     PLL reset
//   o_drp_enable  DRP enable strobe
//   o_drp_write   DRP write strobe
//   o_drp_addr    DRP register address
//   o_drp_data    DRP write data
//   i_drp_ready   DRP ready from the PLL
//   o_busy        sequence in progress
//   o_done        1-cycle pulse once the PLL has locked in the new mode
//   o_error       sticky DRP-ready or lock timeout; cleared only by i_rst
//   o_mode_ntsc   mode currently programmed; valid when busy = 0 and error = 0
module pll_reconfig_ctrl #(
  parameter int unsigned RST_SETTLE   = 4,
  parameter int unsigned RDY_TIMEOUT  = 64,
  parameter int unsigned LOCK_TIMEOUT = 100000
) (
  input  logic        i_drp_clk,
  input  logic        i_rst,
  input  logic        i_ntsc_sel,
  input  logic        i_pll_locked,
  output logic        o_pll_rst,
  output logic        o_drp_enable,
  output logic        o_drp_write,
  output logic [6:0]  o_drp_addr,
  output logic [15:0] o_drp_data,
  input  logic        i_drp_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic        o_mode_ntsc
);

  localparam int unsigned NumRegs = 12;
  localparam int unsigned HoldW   = $clog2(RST_SETTLE + 1);
  localparam int unsigned RdyW    = $clog2(RDY_TIMEOUT + 1);
  localparam int unsigned LockW   = $clog2(LOCK_TIMEOUT + 1);

  // CLKOUT0: O0 = 13 (PAL, odd: 6/7 with edge bit) and O0 = 12 (NTSC, 6/6)
  localparam logic [15:0] Clk0R1Pal  = 16'h0187;
  localparam logic [15:0] Clk0R2Pal  = 16'h0080;
  localparam logic [15:0] Clk0R1Ntsc = 16'h0186;
  localparam logic [15:0] Clk0R2Ntsc = 16'h0000;
  // CLKOUT1: O1 = 52 (26/26) and O1 = 48 (24/24)
  localparam logic [15:0] Clk1R1Pal  = 16'h069A;
  localparam logic [15:0] Clk1R2Pal  = 16'h0000;
  localparam logic [15:0] Clk1R1Ntsc = 16'h0618;
  localparam logic [15:0] Clk1R2Ntsc = 16'h0000;
  // CLKFBOUT: M = 59 (29/30, edge) and M = 55 (27/28, edge)
  localparam logic [15:0] FbR1Pal    = 16'h075E;
  localparam logic [15:0] FbR2Pal    = 16'h0080;
  localparam logic [15:0] FbR1Ntsc   = 16'h06DC;
  localparam logic [15:0] FbR2Ntsc   = 16'h0080;
  // DIVCLK: D = 2 in both modes
  localparam logic [15:0] DivR       = 16'h0041;
  // Lock-detect words; both multipliers fall in the same lookup bucket
  localparam logic [15:0] Lock1      = 16'h03E8;
  localparam logic [15:0] Lock2      = 16'h0401;
  localparam logic [15:0] Lock3      = 16'h1BE9;
  // Loop-filter words
  localparam logic [15:0] Filt1Pal   = 16'h0800;
  localparam logic [15:0] Filt2Pal   = 16'h9000;
  localparam logic [15:0] Filt1Ntsc  = 16'h0800;
  localparam logic [15:0] Filt2Ntsc  = 16'h1900;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StHold,
    StWrite,
    StWaitRdy,
    StRelease,
    StWaitLock,
    StError
  } state_e;

  // Returns {addr, data} for one table slot
  function automatic logic [22:0] tbl_word(input logic ntsc, input logic [3:0] idx);
    logic [22:0] w;
    w = '0;
    case (idx)
      4'd0:    w = {7'h08, ntsc ? Clk0R1Ntsc : Clk0R1Pal};
      4'd1:    w = {7'h09, ntsc ? Clk0R2Ntsc : Clk0R2Pal};
      4'd2:    w = {7'h0A, ntsc ? Clk1R1Ntsc : Clk1R1Pal};
      4'd3:    w = {7'h0B, ntsc ? Clk1R2Ntsc : Clk1R2Pal};
      4'd4:    w = {7'h14, ntsc ? FbR1Ntsc : FbR1Pal};
      4'd5:    w = {7'h15, ntsc ? FbR2Ntsc : FbR2Pal};
      4'd6:    w = {7'h16, DivR};
      4'd7:    w = {7'h18, Lock1};
      4'd8:    w = {7'h19, Lock2};
      4'd9:    w = {7'h1A, Lock3};
      4'd10:   w = {7'h4E, ntsc ? Filt1Ntsc : Filt1Pal};
      4'd11:   w = {7'h4F, ntsc ? Filt2Ntsc : Filt2Pal};
      default: w = '0;
    endcase
    return w;
  endfunction

  state_e            r_state, w_state_d;
  logic              r_req, w_req_d;
  logic              r_mode, w_mode_d;
  logic              r_done, w_done_d;
  logic [3:0]        r_idx, w_idx_d;
  logic [6:0]        r_addr;
  logic [15:0]       r_data;
  logic              w_load;
  logic [HoldW-1:0]  r_hold_cnt, w_hold_cnt_d;
  logic [RdyW-1:0]   r_rdy_cnt, w_rdy_cnt_d;
  logic [LockW-1:0]  r_lock_cnt, w_lock_cnt_d;
  logic              r_lock_s1, r_lock_s2;
  logic [22:0]       w_word;

  assign w_word = tbl_word(r_req, w_idx_d);

  always_comb begin
    w_state_d = r_state;
    w_req_d   = r_req;
    w_mode_d  = r_mode;
    w_done_d  = 1'b0;
    w_idx_d   = r_idx;
    w_load    = 1'b0;
    unique case (r_state)
      // After any reset the PLL may be half-written, so always reprogram it
      StInit: begin
        w_req_d   = i_ntsc_sel;
        w_state_d = StHold;
      end
      StIdle: begin
        if (i_ntsc_sel != r_mode) begin
          w_req_d   = i_ntsc_sel;
          w_state_d = StHold;
        end
      end
      StHold: begin
        w_idx_d = '0;
        if (r_hold_cnt == HoldW'(RST_SETTLE - 1)) begin
          w_state_d = StWrite;
          w_load    = 1'b1;
        end
      end
      StWrite: w_state_d = StWaitRdy;
      StWaitRdy: begin
        if (i_drp_ready) begin
          if (r_idx == 4'(NumRegs - 1)) begin
            w_state_d = StRelease;
          end else begin
            w_idx_d   = r_idx + 4'd1;
            w_state_d = StWrite;
            w_load    = 1'b1;
          end
        end else if (r_rdy_cnt == RdyW'(RDY_TIMEOUT - 1)) begin
          w_state_d = StError;
        end
      end
      StRelease: w_state_d = StWaitLock;
      StWaitLock: begin
        if (r_lock_s2) begin
          w_done_d  = 1'b1;
          w_mode_d  = r_req;
          w_state_d = StIdle;
        end else if (r_lock_cnt == LockW'(LOCK_TIMEOUT - 1)) begin
          w_state_d = StError;
        end
      end
      StError: w_state_d = StError;
      default: w_state_d = StError;
    endcase
  end

  // Per-state timeout counters: zero outside their state, saturating inside it
  always_comb begin
    w_hold_cnt_d = '0;
    w_rdy_cnt_d  = '0;
    w_lock_cnt_d = '0;
    if (r_state == StHold) begin
      w_hold_cnt_d = (r_hold_cnt == HoldW'(RST_SETTLE)) ? r_hold_cnt : r_hold_cnt + 1'b1;
    end
    if (r_state == StWaitRdy) begin
      w_rdy_cnt_d = (r_rdy_cnt == RdyW'(RDY_TIMEOUT)) ? r_rdy_cnt : r_rdy_cnt + 1'b1;
    end
    if (r_state == StWaitLock) begin
      w_lock_cnt_d = (r_lock_cnt == LockW'(LOCK_TIMEOUT)) ? r_lock_cnt : r_lock_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_drp_clk) begin
    if (i_rst) begin
      r_state    <= StInit;
      r_req      <= 1'b0;
      r_mode     <= 1'b0;
      r_done     <= 1'b0;
      r_idx      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_hold_cnt <= '0;
      r_rdy_cnt  <= '0;
      r_lock_cnt <= '0;
      r_lock_s1  <= 1'b0;
      r_lock_s2  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_req      <= w_req_d;
      r_mode     <= w_mode_d;
      r_done     <= w_done_d;
      r_idx      <= w_idx_d;
      r_hold_cnt <= w_hold_cnt_d;
      r_rdy_cnt  <= w_rdy_cnt_d;
      r_lock_cnt <= w_lock_cnt_d;
      r_lock_s1  <= i_pll_locked;
      r_lock_s2  <= r_lock_s1;
      // Address/data only change when a write is about to be issued
      if (w_load) begin
        r_addr <= w_word[22:16];
        r_data <= w_word[15:0];
      end
    end
  end

  assign o_pll_rst    = !((r_state == StRelease) || (r_state == StWaitLock) ||
                          (r_state == StIdle));
  assign o_drp_enable = (r_state == StWrite);
  assign o_drp_write  = (r_state == StWrite);
  assign o_drp_addr   = r_addr;
  assign o_drp_data   = r_data;
  assign o_busy       = !((r_state == StIdle) || (r_state == StError));
  assign o_done       = r_done;
  assign o_error      = (r_state == StError);
  assign o_mode_ntsc  = r_mode;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl. A scoreboard queue holds the expected DRP writes;
// a negedge monitor pops and compares them. The same monitor models DRP ready (2 cycles after a
// write) and PLL lock (50 cycles after reset release).
module tb_pll_reconfig_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ntsc_sel = 1'b0;
  logic        pll_locked = 1'b0;
  logic        drp_ready = 1'b0;
  logic        pll_rst, drp_enable, drp_write, busy, done, error, mode_ntsc;
  logic [6:0]  drp_addr;
  logic [15:0] drp_data;

  int checks = 0;
  int errors = 0;
  int writes = 0;
  int drop_at = -1;
  int rdy_cd = 0;
  int lock_cnt = 0;
  bit outstanding = 1'b0;
  bit prev_en = 1'b0;
  logic [22:0] sb_q[$];

  logic [22:0] pal_tbl [12] = '{
    {7'h08, 16'h0187}, {7'h09, 16'h0080}, {7'h0A, 16'h069A}, {7'h0B, 16'h0000},
    {7'h14, 16'h075E}, {7'h15, 16'h0080}, {7'h16, 16'h0041}, {7'h18, 16'h03E8},
    {7'h19, 16'h0401}, {7'h1A, 16'h1BE9}, {7'h4E, 16'h0800}, {7'h4F, 16'h9000}};
  logic [22:0] ntsc_tbl [12] = '{
    {7'h08, 16'h0186}, {7'h09, 16'h0000}, {7'h0A, 16'h0618}, {7'h0B, 16'h0000},
    {7'h14, 16'h06DC}, {7'h15, 16'h0080}, {7'h16, 16'h0041}, {7'h18, 16'h03E8},
    {7'h19, 16'h0401}, {7'h1A, 16'h1BE9}, {7'h4E, 16'h0800}, {7'h4F, 16'h1900}};

  always #5 clk = ~clk;

  pll_reconfig_ctrl dut (
    .i_drp_clk    (clk),
    .i_rst        (rst),
    .i_ntsc_sel   (ntsc_sel),
    .i_pll_locked (pll_locked),
    .o_pll_rst    (pll_rst),
    .o_drp_enable (drp_enable),
    .o_drp_write  (drp_write),
    .o_drp_addr   (drp_addr),
    .o_drp_data   (drp_data),
    .i_drp_ready  (drp_ready),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
    .o_mode_ntsc  (mode_ntsc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_seq(input logic ntsc, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(ntsc ? ntsc_tbl[i] : pal_tbl[i]);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pll_rst"}, 32'(pll_rst), 1);
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_enable"}, 32'(drp_enable), 0);
    check({tag, "_write"}, 32'(drp_write), 0);
    check({tag, "_addr"}, 32'(drp_addr), 0);
    check({tag, "_data"}, 32'(drp_data), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_mode"}, 32'(mode_ntsc), 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 1);
  endtask

  // Monitor, scoreboard consumer, DRP ready model and PLL lock model
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 1'b0;
      prev_en     = 1'b0;
      rdy_cd      = 0;
      drp_ready   = 1'b0;
    end else begin
      drp_ready = 1'b0;
      check("write_eq_enable", 32'(drp_write), 32'(drp_enable));
      if (drp_enable === 1'b1) begin
        writes++;
        check("strobe_one_cycle", 32'(prev_en), 0);
        check("no_write_before_ready", 32'(outstanding), 0);
        check("pll_rst_during_write", 32'(pll_rst), 1);
        check("sb_nonempty", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) check("drp_addr_data", 32'({drp_addr, drp_data}),
                                    32'(sb_q.pop_front()));
        outstanding = 1'b1;
        if (writes != drop_at) rdy_cd = 2;
      end else if (rdy_cd != 0) begin
        rdy_cd--;
        if (rdy_cd == 0) begin
          drp_ready   = 1'b1;
          outstanding = 1'b0;
        end
      end
      prev_en = drp_enable;
    end
    if (pll_rst !== 1'b0) begin
      lock_cnt   = 0;
      pll_locked = 1'b0;
    end else begin
      lock_cnt++;
      if (lock_cnt >= 50) pll_locked = 1'b1;
    end
  end

  initial begin
    int base;
    int n;
    bit found;

    // Reset state, then forced PAL sequence out of reset
    rst = 1'b1;
    ntsc_sel = 1'b0;
    repeat (3) tick();
    check_reset("reset1");
    push_seq(1'b0, 12);
    base = writes;
    rst = 1'b0;
    wait_done("pal_init", 400);
    check("pal_init_writes", writes - base, 12);
    check("pal_init_mode", 32'(mode_ntsc), 0);
    check("pal_init_busy", 32'(busy), 0);
    check("pal_init_pll_rst", 32'(pll_rst), 0);
    check("pal_init_sb_empty", sb_q.size(), 0);
    tick();
    check("done_one_cycle", 32'(done), 0);

    // PAL -> NTSC
    base = writes;
    ntsc_sel = 1'b1;
    push_seq(1'b1, 12);
    tick();
    check("ntsc_busy_next", 32'(busy), 1);
    check("ntsc_pll_rst_next", 32'(pll_rst), 1);
    n = 1;
    for (int i = 0; i < 20 && drp_enable !== 1'b1; i++) begin
      tick();
      if (drp_enable !== 1'b1) n++;
    end
    check("ntsc_hold_cycles", n, 4);
    wait_done("ntsc", 400);
    check("ntsc_writes", writes - base, 12);
    check("ntsc_mode", 32'(mode_ntsc), 1);
    check("ntsc_sb_empty", sb_q.size(), 0);

    // Toggle request mid-sequence: PAL completes, then NTSC starts right after done
    tick();
    base = writes;
    ntsc_sel = 1'b0;
    push_seq(1'b0, 12);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (writes - base >= 3) found = 1'b1;
    end
    check("toggle_reached_write3", 32'(found), 1);
    ntsc_sel = 1'b1;
    push_seq(1'b1, 12);
    wait_done("toggle_first", 400);
    check("toggle_first_mode", 32'(mode_ntsc), 0);
    check("toggle_first_busy", 32'(busy), 0);
    tick();
    check("toggle_restart_busy", 32'(busy), 1);
    wait_done("toggle_second", 400);
    check("toggle_second_mode", 32'(mode_ntsc), 1);
    check("toggle_writes", writes - base, 24);
    check("toggle_sb_empty", sb_q.size(), 0);

    // Reset while the 5th write is on the bus: full PAL sequence follows
    tick();
    base = writes;
    ntsc_sel = 1'b0;
    push_seq(1'b0, 12);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (drp_enable === 1'b1 && writes == base + 4) found = 1'b1;
    end
    check("midrst_reached_write5", 32'(found), 1);
    rst = 1'b1;
    sb_q.delete();
    tick();
    tick();
    check_reset("reset2");
    push_seq(1'b0, 12);
    base = writes;
    rst = 1'b0;
    wait_done("midrst", 400);
    check("midrst_writes", writes - base, 12);
    check("midrst_mode", 32'(mode_ntsc), 0);
    check("midrst_sb_empty", sb_q.size(), 0);

    // DRP ready never returned for the 3rd write: error after the ready timeout
    tick();
    base = writes;
    drop_at = base + 3;
    ntsc_sel = 1'b1;
    push_seq(1'b1, 3);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (drp_enable === 1'b1 && writes == base + 2) found = 1'b1;
    end
    check("err_reached_write3", 32'(found), 1);
    repeat (64) tick();
    check("err_not_yet", 32'(error), 0);
    check("err_still_busy", 32'(busy), 1);
    tick();
    check("err_set", 32'(error), 1);
    check("err_pll_rst", 32'(pll_rst), 1);
    check("err_busy", 32'(busy), 0);
    repeat (200) tick();
    check("err_sticky", 32'(error), 1);
    check("err_no_more_writes", writes - base, 3);
    check("err_no_done_mode", 32'(mode_ntsc), 0);
    rst = 1'b1;
    tick();
    tick();
    check_reset("reset3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
